load_store_unit: RTL and testbench
==================================

// Module: load_store_unit
// PURPOSE
//  Data-memory access stage for loads and stores. Takes the ALU-computed address, funct3 and rs2
//  data, runs one bus transaction with a req/ready handshake, and stalls the core while waiting.
//  Produces the aligned, sign/zero-extended load word that feeds the register-write select mux
//  (sel = 01). Detects misaligned or illegal accesses and bus timeouts before/while accessing.
// PARAMETERS
//  TIMEOUT  256  max cycles in REQ without mem_ready before fault 11; 0 = never time out
// PORTS
//  clk          in   1   single system clock, rising edge
//  rst          in   1   asynchronous, active-high reset
//  start        in   1   memory instruction present this cycle (level; sampled only in IDLE)
//  is_store     in   1   1 = store, 0 = load
//  funct3       in   3   RV32I load/store width/sign field
//  addr         in   32  byte address from ALU
//  store_data   in   32  rs2 value
//  busy         out  1   stall PC/pipeline
//  done         out  1   1-cycle pulse: access finished (load_result/fault valid)
//  load_result  out  32  extended load data, to register-write mux
//  fault        out  2   00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid with done
//  mem_req      out  1   bus request, held until mem_ready
//  mem_we       out  1   1 = write
//  mem_addr     out  32  word address ({addr[31:2],2'b00})
//  mem_wdata    out  32  lane-replicated store data
//  mem_wstrb    out  4   byte enables (0000 on reads)
//  mem_rdata    in   32  read word, valid when mem_ready
//  mem_ready    in   1   slave completes transfer this cycle
// BEHAVIOUR
//  - Reset (async): state IDLE; busy=0 (when start=0), done=0, load_result=0, fault=00, mem_req=0,
//    mem_we=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, timeout counter=0. Asserted mid-transfer:
//    mem_req drops immediately, transaction is abandoned, no done pulse.
//  - FSM IDLE -> REQ -> RESP -> IDLE; IDLE -> RESP directly on fault 01/10 (no bus access).
//  - IDLE: start=1 -> capture is_store/funct3/addr[1:0], drive bus regs, go REQ (mem_req=1 next cycle).
//    Checks in IDLE: illegal funct3 (load 011/110/111, store 1xx/011) -> fault 10; else halfword with
//    addr[0]=1 or word with addr[1:0]!=00 -> fault 01. Illegal wins over misaligned.
//  - REQ: mem_req/we/addr/wdata/wstrb held stable. mem_ready=1 -> go RESP; loads latch the extended
//    mem_rdata into load_result at that edge. Counter counts REQ cycles; reaching TIMEOUT -> RESP
//    with fault 11, mem_req drops, load_result unchanged.
//  - RESP: done=1 for exactly one cycle, fault valid, busy=0; next state IDLE. A new start is sampled
//    in the following IDLE cycle, never in RESP.
//  - busy = (state==IDLE & start) | (state==REQ); combinational, so the stall applies in the start cycle.
//  - Latency: start @t0, mem_req @t1, mem_ready @tN -> done @tN+1. Minimum 2 cycles (ready at t1).
//  - Loads: LB/LBU pick byte addr[1:0]; LH/LHU pick half addr[1]; sign- (LB/LH) or zero-extend
//    (LBU/LHU); LW whole word. load_result holds its value across stores and faults.
//  - Stores: SB wdata={4{b}}, wstrb=0001<<addr[1:0]; SH wdata={2{h}}, wstrb=0011<<{addr[1],1'b0};
//    SW wdata=word, wstrb=1111.
// STRUCTURE
//  - Shared include lsu_defs.vh: funct3 encodings (LB..LHU, SB..SW), FSM state encoding, fault codes.
//  - One combinational sub-module lsu_lane_align: store replication/strobe + load extraction/extend.
//  - Top: FSM, timeout counter, bus output registers, load_result register.
// TESTING
//  - LW addr=0x100, rdata=0xDEADBEEF, ready at t1 -> mem_addr=0x100, wstrb=0000, done @t2,
//    load_result=0xDEADBEEF, fault=00, busy high t0..t1.
//  - LB addr=0x103, rdata=0x80FF_0000 -> load_result=0xFFFFFF80; LBU same -> 0x00000080;
//    LHU addr=0x102 -> 0x000080FF.
//  - SB addr=0x202, data=0x12345678 -> mem_we=1, wdata=0x78787878, wstrb=0100, mem_addr=0x200;
//    ready delayed 5 cycles -> mem_req held stable 6 cycles, busy high throughout, single done.
//  - LW addr=0x102 -> fault=01, no mem_req ever, done @t1; load funct3=011 @addr 0x102 -> fault=10.
//  - TIMEOUT=4, ready never asserted -> mem_req high 4 cycles, then done with fault=11,
//    load_result unchanged.
//  - rst pulsed while in REQ -> mem_req=0 same cycle, no done; next start completes normally.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 width encodings,
// FSM states, fault codes and the access legality checks.
package load_store_unit_pkg;

   // RV32I funct3 encodings (stores reuse the signed byte/half/word codes)
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_REQ  = 2'b01,
      ST_RESP = 2'b10
   } lsu_state_t;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_MISALIGN = 2'b01,
      FAULT_ILLEGAL  = 2'b10,
      FAULT_TIMEOUT  = 2'b11
   } lsu_fault_t;

   // Stores only have signed-looking byte/half/word codes; loads add the unsigned variants
   function automatic logic f3_illegal(input logic store, input logic [2:0] f3);
      if (store) return !(f3 inside {F3_B, F3_H, F3_W});
      return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
   endfunction

   // funct3[1:0] carries the access size, so one check serves loads and stores
   function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] offset);
      case (f3[1:0])
         2'b01:   return offset[0];
         2'b10:   return offset != 2'b00;
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_lane_align.sv
// Byte-lane steering: replicates store data across lanes with matching
// strobes, and extracts plus sign/zero-extends load data from a bus word.
module load_store_unit_lane_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  st_funct3,
   input  logic [1:0]  st_offset,
   input  logic [31:0] store_data,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   input  logic [2:0]  ld_funct3,
   input  logic [1:0]  ld_offset,
   input  logic [31:0] rdata,
   output logic [31:0] load_value
);

   logic [31:0] shifted;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Store side: replicate the datum into every lane, strobe only the addressed ones
   always_comb begin
      wdata = store_data;
      wstrb = 4'b1111;
      case (st_funct3[1:0])
         2'b00: begin
            wdata = {4{store_data[7:0]}};
            wstrb = 4'b0001 << st_offset;
         end
         2'b01: begin
            wdata = {2{store_data[15:0]}};
            wstrb = 4'b0011 << {st_offset[1], 1'b0};
         end
         default: begin
            wdata = store_data;
            wstrb = 4'b1111;
         end
      endcase
   end

   // Load side: pick the addressed byte/half and extend it to 32 bits
   always_comb begin
      shifted    = rdata >> {ld_offset, 3'b000};
      byte_sel   = shifted[7:0];
      half_sel   = ld_offset[1] ? rdata[31:16] : rdata[15:0];
      load_value = rdata;
      case (ld_funct3)
         F3_B:    load_value = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   load_value = {24'h000000, byte_sel};
         F3_H:    load_value = {{16{half_sel[15]}}, half_sel};
         F3_HU:   load_value = {16'h0000, half_sel};
         default: load_value = rdata;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Data-memory access stage: one req/ready bus transaction per memory
// instruction, stalling the core while it waits, with misalignment,
// illegal-funct3 and bus-timeout detection.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        is_store,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic        busy,
   output logic        done,
   output logic [31:0] load_result,
   output logic [1:0]  fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic [31:0] mem_rdata,
   input  logic        mem_ready
);

   localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT - 1);

   lsu_state_t  state;
   lsu_fault_t  fault_q;
   logic        cap_store;
   logic [2:0]  cap_funct3;
   logic [1:0]  cap_offset;
   logic [31:0] cnt;
   logic [31:0] lane_wdata;
   logic [3:0]  lane_wstrb;
   logic [31:0] load_value;

   // Store steering uses the live instruction; load extraction uses the captured one
   load_store_unit_lane_align u_lane_align (
      .st_funct3  (funct3),
      .st_offset  (addr[1:0]),
      .store_data (store_data),
      .wdata      (lane_wdata),
      .wstrb      (lane_wstrb),
      .ld_funct3  (cap_funct3),
      .ld_offset  (cap_offset),
      .rdata      (mem_rdata),
      .load_value (load_value)
   );

   // Stall is combinational so the pipeline freezes in the very cycle start appears
   assign busy  = ((state == ST_IDLE) && start) || (state == ST_REQ);
   assign fault = fault_q;

   // Access FSM with registered bus signals, timeout counter and load result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         fault_q     <= FAULT_NONE;
         done        <= 1'b0;
         load_result <= 32'h0;
         mem_req     <= 1'b0;
         mem_we      <= 1'b0;
         mem_addr    <= 32'h0;
         mem_wdata   <= 32'h0;
         mem_wstrb   <= 4'b0000;
         cnt         <= 32'h0;
         cap_store   <= 1'b0;
         cap_funct3  <= 3'b000;
         cap_offset  <= 2'b00;
      end else begin
         done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  cap_store  <= is_store;
                  cap_funct3 <= funct3;
                  cap_offset <= addr[1:0];
                  if (f3_illegal(is_store, funct3)) begin
                     fault_q <= FAULT_ILLEGAL;
                     done    <= 1'b1;
                     state   <= ST_RESP;
                  end else if (f3_misaligned(funct3, addr[1:0])) begin
                     fault_q <= FAULT_MISALIGN;
                     done    <= 1'b1;
                     state   <= ST_RESP;
                  end else begin
                     fault_q   <= FAULT_NONE;
                     mem_req   <= 1'b1;
                     mem_we    <= is_store;
                     mem_addr  <= {addr[31:2], 2'b00};
                     mem_wdata <= lane_wdata;
                     mem_wstrb <= is_store ? lane_wstrb : 4'b0000;
                     cnt       <= 32'h0;
                     state     <= ST_REQ;
                  end
               end
            end
            ST_REQ: begin
               if (mem_ready) begin
                  mem_req <= 1'b0;
                  done    <= 1'b1;
                  state   <= ST_RESP;
                  if (!cap_store) load_result <= load_value;
               end else if ((TIMEOUT != 0) && (cnt == TIMEOUT_LAST)) begin
                  mem_req <= 1'b0;
                  fault_q <= FAULT_TIMEOUT;
                  done    <= 1'b1;
                  state   <= ST_RESP;
               end else begin
                  cnt <= cnt + 32'h1;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed scenarios plus randomized
// accesses compared against a byte-level reference model.
module tb_load_store_unit;

   localparam int TIMEOUT = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] store_data = 32'h0;
   logic        busy;
   logic        done;
   logic [31:0] load_result;
   logic [1:0]  fault;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ready = 1'b0;

   int vectorCount = 0;
   int missCount = 0;
   logic [31:0] modelLoad = 32'h0;

   load_store_unit #(.TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .is_store    (is_store),
      .funct3      (funct3),
      .addr        (addr),
      .store_data  (store_data),
      .busy        (busy),
      .done        (done),
      .load_result (load_result),
      .fault       (fault),
      .mem_req     (mem_req),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .mem_wstrb   (mem_wstrb),
      .mem_rdata   (mem_rdata),
      .mem_ready   (mem_ready)
   );

   // 10-unit clock
   always #5 clk = ~clk;

   // Hard stop in case something never returns
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      vectorCount++;
      if (actual !== expected) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   task automatic nextCycle();
      @(negedge clk);
      #1;
   endtask

   // Reference: which funct3 values exist for each direction
   function automatic bit refLegal(input bit st, input logic [2:0] f3);
      if (st) return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2);
      return (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
   endfunction

   // Reference: access size in bytes must divide the address
   function automatic bit refAligned(input logic [2:0] f3, input logic [31:0] a);
      int size;
      size = (f3 == 3'd0 || f3 == 3'd4) ? 1 : (f3 == 3'd1 || f3 == 3'd5) ? 2 : 4;
      return (a % size) == 0;
   endfunction

   // Reference load extraction with arithmetic sign handling
   function automatic logic [31:0] refLoad(input logic [2:0] f3, input int off, input logic [31:0] rdata);
      int v;
      logic [31:0] w;
      case (f3)
         3'd0, 3'd4: begin
            w = rdata >> (8 * off);
            v = int'(w & 32'hFF);
            if (f3 == 3'd0 && v >= 128) v = v - 256;
            return 32'(v);
         end
         3'd1, 3'd5: begin
            w = rdata >> (16 * (off / 2));
            v = int'(w & 32'hFFFF);
            if (f3 == 3'd1 && v >= 32768) v = v - 65536;
            return 32'(v);
         end
         default: return rdata;
      endcase
   endfunction

   function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] d);
      if (f3 == 3'd0) return (d & 32'hFF) * 32'h01010101;
      if (f3 == 3'd1) return (d & 32'hFFFF) * 32'h00010001;
      return d;
   endfunction

   function automatic logic [3:0] refWstrb(input logic [2:0] f3, input int off);
      if (f3 == 3'd0) return 4'(1 << off);
      if (f3 == 3'd1) return 4'(3 << off);
      return 4'hF;
   endfunction

   // One complete access; readyDelay < 0 means the slave never answers
   task automatic applyStimulus(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] sdata, input logic [31:0] rdata, input int readyDelay);
      logic [1:0]  expFault;
      logic [31:0] expAddr;
      logic [31:0] expWdata;
      logic [3:0]  expWstrb;
      bit          hit;
      int          off;
      off = int'(a % 4);
      if (!refLegal(st, f3))        expFault = 2'b10;
      else if (!refAligned(f3, a))  expFault = 2'b01;
      else                          expFault = 2'b00;

      start = 1'b1; is_store = st; funct3 = f3; addr = a; store_data = sdata; mem_ready = 1'b0;
      #1;
      checkOutput("busy_start", 32'(busy), 32'd1);
      nextCycle();
      start = 1'b0; addr = $urandom; store_data = $urandom; funct3 = 3'($urandom); is_store = 1'($urandom);

      if (expFault != 2'b00) begin
         checkOutput("early_done", 32'(done), 32'd1);
         checkOutput("early_fault", 32'(fault), 32'(expFault));
         checkOutput("early_noreq", 32'(mem_req), 32'd0);
         checkOutput("early_busy", 32'(busy), 32'd0);
         checkOutput("early_load", load_result, modelLoad);
      end else begin
         expAddr  = a & 32'hFFFF_FFFC;
         expWdata = refWdata(f3, sdata);
         expWstrb = st ? refWstrb(f3, off) : 4'h0;
         hit = 1'b0;
         for (int k = 0; k < TIMEOUT; k++) begin
            checkOutput("req_held", 32'(mem_req), 32'd1);
            checkOutput("req_busy", 32'(busy), 32'd1);
            checkOutput("req_done", 32'(done), 32'd0);
            checkOutput("req_addr", mem_addr, expAddr);
            if (k == 0) begin
               checkOutput("req_we", 32'(mem_we), 32'(st));
               checkOutput("req_wstrb", 32'(mem_wstrb), 32'(expWstrb));
               if (st) checkOutput("req_wdata", mem_wdata, expWdata);
            end
            if (k == readyDelay) begin
               mem_ready = 1'b1;
               mem_rdata = rdata;
               nextCycle();
               mem_ready = 1'b0;
               mem_rdata = $urandom;
               hit = 1'b1;
               break;
            end
            mem_rdata = $urandom;
            nextCycle();
         end
         if (!hit) expFault = 2'b11;
         else if (!st) modelLoad = refLoad(f3, off, rdata);
         checkOutput("resp_done", 32'(done), 32'd1);
         checkOutput("resp_fault", 32'(fault), 32'(expFault));
         checkOutput("resp_noreq", 32'(mem_req), 32'd0);
         checkOutput("resp_busy", 32'(busy), 32'd0);
         checkOutput("resp_load", load_result, modelLoad);
      end
      nextCycle();
      checkOutput("done_pulse", 32'(done), 32'd0);
   endtask

   initial begin
      #1 rst = 1'b1;
      nextCycle();
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_load", load_result, 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_req", 32'(mem_req), 32'd0);
      checkOutput("rst_we", 32'(mem_we), 32'd0);
      checkOutput("rst_addr", mem_addr, 32'd0);
      checkOutput("rst_wdata", mem_wdata, 32'd0);
      checkOutput("rst_wstrb", 32'(mem_wstrb), 32'd0);
      rst = 1'b0;
      nextCycle();

      $display("[TB] directed accesses");
      applyStimulus(1'b0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0);
      checkOutput("lw_value", load_result, 32'hDEADBEEF);
      applyStimulus(1'b0, 3'd0, 32'h103, 32'h0, 32'h80FF_0000, 1);
      checkOutput("lb_value", load_result, 32'hFFFFFF80);
      applyStimulus(1'b0, 3'd4, 32'h103, 32'h0, 32'h80FF_0000, 2);
      checkOutput("lbu_value", load_result, 32'h00000080);
      applyStimulus(1'b0, 3'd5, 32'h102, 32'h0, 32'h80FF_0000, 0);
      checkOutput("lhu_value", load_result, 32'h000080FF);
      applyStimulus(1'b1, 3'd0, 32'h202, 32'h12345678, 32'h0, 5);
      checkOutput("sb_keeps_load", load_result, 32'h000080FF);
      applyStimulus(1'b0, 3'd2, 32'h102, 32'h0, 32'h0, 0);
      applyStimulus(1'b0, 3'd3, 32'h102, 32'h0, 32'h0, 0);
      applyStimulus(1'b1, 3'd4, 32'h100, 32'h0, 32'h0, 0);
      applyStimulus(1'b0, 3'd2, 32'h300, 32'h0, 32'h0, -1);
      checkOutput("timeout_keeps_load", load_result, 32'h000080FF);

      $display("[TB] reset during request");
      start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h400;
      nextCycle();
      start = 1'b0;
      checkOutput("pre_rst_req", 32'(mem_req), 32'd1);
      nextCycle();
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_req", 32'(mem_req), 32'd0);
      checkOutput("mid_rst_busy", 32'(busy), 32'd0);
      checkOutput("mid_rst_done", 32'(done), 32'd0);
      nextCycle();
      rst = 1'b0;
      modelLoad = 32'h0;
      nextCycle();
      checkOutput("post_rst_done", 32'(done), 32'd0);
      checkOutput("post_rst_load", load_result, 32'h0);
      applyStimulus(1'b0, 3'd2, 32'h404, 32'h0, 32'hCAFEF00D, 3);

      $display("[TB] random accesses");
      for (int n = 0; n < 150; n++) begin
         applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                       int'($urandom_range(0, TIMEOUT + 1)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

endmodule
